// File: rtl/sort_frame_loader.sv
// Serial-to-parallel frame collector feeding the bitonic sorter; holds each frame until acknowledged.
// Optional short-frame padding via `define SORT_FRAME_LOADER_PAD_EN.
module sort_frame_loader #(
    parameter int unsigned IS_ASC    = 1,
    parameter int unsigned NUM_ELEM  = 8,
    parameter int unsigned SIZE_DATA = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [SIZE_DATA-1:0]              i_data,
    input  logic                              i_last,
    output logic                              o_frame_valid,
    input  logic                              i_frame_ready,
    output logic [SIZE_DATA-1:0]              o_frame [0:NUM_ELEM-1],
    output logic [$clog2(NUM_ELEM+1)-1:0]     o_count
);

    localparam int unsigned IW = $clog2(NUM_ELEM);
    localparam int unsigned CW = $clog2(NUM_ELEM + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEM - 1);

    typedef enum logic {StFill, StHold} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        count_q, count_d;
    logic [SIZE_DATA-1:0] frame_q [0:NUM_ELEM-1];
    logic [SIZE_DATA-1:0] frame_d [0:NUM_ELEM-1];

`ifdef SORT_FRAME_LOADER_PAD_EN
    // Pad value sorts to the tail for the downstream direction.
    localparam logic [SIZE_DATA-1:0] PAD = (IS_ASC != 0) ? '1 : '0;
`else
    logic unused_pad_cfg;
    assign unused_pad_cfg = i_last ^ (IS_ASC != 0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        frame_d = frame_q;
        unique case (state_q)
            StFill: begin
                if (i_valid) begin
                    frame_d[idx_q] = i_data;
                    idx_d          = idx_q + IW'(1);
                    count_d        = count_q + CW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = StHold;
                        idx_d   = '0;
                    end
`ifdef SORT_FRAME_LOADER_PAD_EN
                    else if (i_last) begin
                        state_d = StHold;
                        idx_d   = '0;
                        for (int k = 0; k < int'(NUM_ELEM); k++) begin
                            if (IW'(k) > idx_q) frame_d[k] = PAD;
                        end
                    end
`endif
                end
            end
            StHold: begin
                // Frame contents stay put; stale slots get overwritten on refill.
                if (i_frame_ready) begin
                    state_d = StFill;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StFill;
            idx_q   <= '0;
            count_q <= '0;
            for (int k = 0; k < int'(NUM_ELEM); k++) frame_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            frame_q <= frame_d;
        end
    end

    assign o_ready       = (state_q == StFill);
    assign o_frame_valid = (state_q == StHold);
    assign o_frame       = frame_q;
    assign o_count       = count_q;

endmodule

// File: doc/sort_frame_loader.md
Name: sort_frame_loader

Overview:
- Serial-to-parallel frame collector directly upstream of the bitonic sorter.
- Accepts one SIZE_DATA word per valid/ready handshake and packs NUM_ELEM words into an unpacked frame array that drives the sorter's i_data.
- Holds each completed frame stable until the consumer acknowledges it, so the sorter sees a constant input for its full pipeline depth.

Parameters:
- IS_ASC, 1, sort direction of the downstream sorter; selects the pad value (1: all-ones, 0: all-zeros).
- NUM_ELEM, 8, words per frame; power of two, >= 2.
- SIZE_DATA, 8, width of one word.

Ports:
- i_clk  in  1  clock; all state on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  loader can accept a word.
- i_data  in  SIZE_DATA  upstream word.
- i_last  in  1  marks the final word of a short frame; used only with the optional feature.
- o_frame_valid  out  1  o_frame is complete and stable.
- i_frame_ready  in  1  consumer accepts the frame.
- o_frame  out  NUM_ELEM x SIZE_DATA  unpacked array [0:NUM_ELEM-1]; element k is the k-th accepted word.
- o_count  out  $clog2(NUM_ELEM+1)  number of real (non-pad) words in the presented frame.

Behaviour:
- Reset (async assert, any state): state=FILL, write index=0, o_frame all zeros, o_count=0, o_frame_valid=0.
  - o_ready=1 after reset deasserts.
- States:
  - FILL: o_ready=1, o_frame_valid=0.
  - HOLD: o_ready=0, o_frame_valid=1.
- FILL: a word is accepted when i_valid && o_ready.
  - The accepted word is written to o_frame[index].
  - index and o_count increment.
- Frame completion: accepting word NUM_ELEM-1 moves the block to HOLD on the same edge.
  - o_frame_valid rises in the next cycle, so latency from the last handshake to frame valid is 1 cycle.
- HOLD:
  - o_frame and o_count are frozen.
  - i_valid is ignored; no word is consumed.
  - When i_frame_ready=1 on an edge: return to FILL, index=0, o_count=0.
  - o_frame contents are retained; stale slots are overwritten on refill.
- No bubble on the input side: o_ready is 1 in the cycle immediately after the frame is accepted.
  - Combinational ready-through (accepting a word in the same cycle as the frame handshake) is not provided.
- i_frame_ready while in FILL: no effect.
- i_valid held high with stable i_data across HOLD: the word is not lost; it is accepted on the first FILL cycle.
- Reset mid-frame: partially collected words are discarded; the next accepted word lands at index 0.
- Index wraps only through the HOLD→FILL transition; it never exceeds NUM_ELEM-1.

Optional Feature:
- Macro: SORT_FRAME_LOADER_PAD_EN.
- Defined:
  - i_last=1 on an accepted word completes the frame early and moves the block to HOLD.
  - Every slot above the last written index is filled with the pad value on the transition into HOLD: all-ones if IS_ASC=1, zero otherwise. Pads therefore sort to the tail of the frame.
  - o_count = number of real words.
  - i_last on word NUM_ELEM-1 behaves like a normal completion.
- Undefined:
  - i_last is ignored; only full NUM_ELEM-word frames are emitted.
  - o_count is always NUM_ELEM when o_frame_valid=1.

Test Plan:
1. Reset, then stream 35,120,0,0,55,100,77,5 with i_valid=1 each cycle and i_frame_ready=0.
   - Required: o_frame_valid rises 1 cycle after the 8th handshake.
   - Required: o_frame = {35,120,0,0,55,100,77,5}, o_count=8, o_ready=0.
2. Hold i_frame_ready=0 for 10 cycles while i_valid=1 with data 9.
   - Required: o_frame unchanged and no word consumed.
   - Then pulse i_frame_ready=1 for one cycle. Required: o_ready=1 next cycle and 9 is written to slot 0.
3. Back-to-back frames: words 1..8 then 11..18, consumer ready=1 throughout.
   - Required: two frames {1..8} and {11..18}.
   - Required: exactly one idle input cycle (HOLD) between the two frames.
4. Assert i_rst after 3 words (7,7,7), then send 8 words 1..8.
   - Required: o_frame_valid=0 immediately on reset assertion.
   - Required: the next frame is {1..8}, o_count=8.
5. With SORT_FRAME_LOADER_PAD_EN and IS_ASC=1, send 4,3,2 with i_last on 2.
   - Required: frame {4,3,2,255,255,255,255,255}, o_count=3.
   - Without the macro: same stimulus leaves o_frame_valid=0 and o_count=3.
6. Random i_valid (50%) and i_frame_ready (30%) for 200 frames of random words.
   - Required: every frame matches the scoreboard in order.
   - Required: no handshake occurs while o_ready=0.
